instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  one-cycle pulse; opens a load session at base_addr; ignored unless in IDLE.
REQ-004 base_addr  in  32  first word address of the session; must be 4-byte aligned.
REQ-005 req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both high on a clock edge.
REQ-006 req_fmt  in  3  instruction format (R, I, S, B, U, J).
REQ-007 req_opcode, req_funct3, req_funct7  in  7 / 3 / 7  raw instruction fields.
REQ-008 req_rd, req_rs1, req_rs2  in  5 each  register indices.
REQ-009 req_imm  in  32  signed byte-offset immediate; for U format, the full 32-bit value.
REQ-010 req_last  in  1  marks the final request of the session.
REQ-011 mem_we  out  1  instruction-memory write strobe.
REQ-012 mem_addr, mem_wdata  out  32 / 32  write address and encoded instruction word.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at end of session.
REQ-015 err  out  1  sticky flag for invalid requests; cleared on start.
REQ-016 word_count  out  16  number of words written in the current session.

Function
REQ-017 FSM states: IDLE, ACCEPT, WRITE, DONE.
REQ-018 IDLE to ACCEPT on start: address register <- base_addr, word_count <- 0, err <- 0.
REQ-019 req_ready is high only in ACCEPT.
REQ-020 ACCEPT with a transfer: latch the encoded word, req_last and validity, then go to WRITE; with no transfer, stay in ACCEPT.
REQ-021 WRITE lasts one cycle. For a valid word it raises mem_we with the current address and word, then advances the address by 4 and word_count by 1.
REQ-022 WRITE next state: DONE if the latched req_last is set, otherwise ACCEPT.
REQ-023 Timing: a request accepted at edge N gives mem_we high in cycle N+1; maximum throughput is one word per two cycles.
REQ-024 DONE asserts done for one cycle, then goes to IDLE.
REQ-025 Encoding follows standard RV32I bit placement for R, I, S, B, U and J formats using the supplied fields. Unused fields are ignored.
REQ-026 Invalid request, any of:
- I/S immediate not representable in 12 signed bits;
- B immediate not in 13 signed bits, or bit0 = 1;
- J immediate not in 21 signed bits, or bit0 = 1;
- U immediate with bits[11:0] not zero;
- req_fmt not one of the six defined formats.
REQ-027 Invalid request: no mem_we, address and word_count unchanged, err set. The req_last of an invalid request still ends the session.
REQ-028 The address wraps modulo 2^32; after 0xFFFFFFFC the next address is 0x00000000.
REQ-029 word_count saturates at 0xFFFF.
REQ-030 start is ignored while busy.

Reset
REQ-031 rst forces IDLE from any state, including mid-WRITE.
REQ-032 Output values under reset: req_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, word_count=0.
REQ-033 No write completes in the cycle rst is asserted.

Structure
REQ-034 Shared package instr_pkg holds:
- the format enum;
- the FSM state enum;
- RV32I opcode constants: LOAD 0000011, STORE 0100011, OP 0110011, BRANCH 1100011, OP_IMM 0010011, AUIPC 0010111, LUI 0110111, JAL 1101111, JALR 1100111.
REQ-035 A purely combinational sub-module imm_packer performs field packing and the range/alignment check, returning the word and a valid bit.

Verification
REQ-036 R format: opcode 0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, base 0x100 -> mem_wdata 0x002081B3 at mem_addr 0x100 exactly one cycle after acceptance.
REQ-037 Three-request session:
- ADDI x1,x0,-1 (I, opcode 0010011, imm 0xFFFFFFFF) -> 0xFFF00093;
- SW x2,8(x1) (S, funct3 010) -> 0x0020A423;
- BEQ x0,x0,-4 (last) -> 0xFE000EE3;
- addresses step by 4, word_count=3, done pulses once.
REQ-038 Address wrap: LUI x5 with imm 0x12345000, base 0xFFFFFFFC, two requests -> 0x123452B7 written at 0xFFFFFFFC, then at 0x00000000.
REQ-039 Invalid request: JAL with imm=3 and last=1 -> no mem_we, err=1, word_count unchanged, done pulses; the next start clears err.
REQ-040 Reset mid-WRITE: rst asserted in the WRITE cycle -> no mem_we, all outputs at reset values, and start then begins a fresh session.
REQ-041 Flow control: req_valid held low for 5 cycles in ACCEPT -> req_ready stays high and no state change; start pulsed during the session is ignored.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared types and constants for the RV32I instruction encoder: formats, FSM states,
// opcodes and the packed request record handed to the field packer.
package instr_pkg;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccept = 2'd1,
    StWrite  = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  // True when v survives truncation to the low 'bits' bits and sign-extension back.
  function automatic logic fits_signed(logic [31:0] v, int unsigned bits);
    logic [31:0] ext;
    ext = $unsigned($signed(v << (32 - bits)) >>> (32 - bits));
    return ext == v;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request, memory-write and status bundle of the instruction encoder.
interface instr_encoder_if;

  logic        start;
  logic [31:0] base_addr;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        req_last;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  modport master (
    output start, base_addr,
    output req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
    output req_rd, req_rs1, req_rs2, req_imm, req_last,
    input  req_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count
  );

  modport slave (
    input  start, base_addr,
    input  req_valid, req_fmt, req_opcode, req_funct3, req_funct7,
    input  req_rd, req_rs1, req_rs2, req_imm, req_last,
    output req_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count
  );

endinterface

// File: rtl/imm_packer.sv
// Combinational RV32I field packer: places fields per format and flags immediates
// that are out of range, misaligned, or belong to an undefined format.
module imm_packer
  import instr_pkg::*;
(
  input  req_t        req_i,
  output logic [31:0] word_o,
  output logic        valid_o
);

  logic [31:0] imm;
  assign imm = req_i.imm;

  always_comb begin
    word_o  = '0;
    valid_o = 1'b0;
    case (req_i.fmt)
      FmtR: begin
        word_o  = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
        valid_o = 1'b1;
      end
      FmtI: begin
        word_o  = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
        valid_o = fits_signed(imm, 12);
      end
      FmtS: begin
        word_o  = {imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3, imm[4:0], req_i.opcode};
        valid_o = fits_signed(imm, 12);
      end
      FmtB: begin
        word_o  = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                   imm[4:1], imm[11], req_i.opcode};
        valid_o = fits_signed(imm, 13) && !imm[0];
      end
      FmtU: begin
        word_o  = {imm[31:12], req_i.rd, req_i.opcode};
        valid_o = (imm[11:0] == 12'h000);
      end
      FmtJ: begin
        word_o  = {imm[20], imm[10:1], imm[11], imm[19:12], req_i.rd, req_i.opcode};
        valid_o = fits_signed(imm, 21) && !imm[0];
      end
      default: begin
        word_o  = '0;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Session-based instruction loader: accepts encode requests, packs them into RV32I words
// and writes each valid word to consecutive instruction-memory addresses.
module instr_encoder
  import instr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus_io
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;

  req_t        req;
  logic [31:0] packed_word;
  logic        packed_valid;
  logic        xfer;

  assign req = '{
    fmt:    bus_io.req_fmt,
    opcode: bus_io.req_opcode,
    funct3: bus_io.req_funct3,
    funct7: bus_io.req_funct7,
    rd:     bus_io.req_rd,
    rs1:    bus_io.req_rs1,
    rs2:    bus_io.req_rs2,
    imm:    bus_io.req_imm
  };

  imm_packer u_imm_packer (
    .req_i   (req),
    .word_o  (packed_word),
    .valid_o (packed_valid)
  );

  assign xfer = (state_q == StAccept) && bus_io.req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
      err_q   <= err_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus_io.start) state_d = StAccept;
      StAccept: if (xfer) state_d = StWrite;
      StWrite:  state_d = last_q ? StDone : StAccept;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    word_d  = word_q;
    count_d = count_q;
    err_d   = err_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (state_q == StIdle && bus_io.start) begin
      addr_d  = bus_io.base_addr;
      count_d = '0;
      err_d   = 1'b0;
    end
    if (xfer) begin
      word_d  = packed_word;
      last_d  = bus_io.req_last;
      valid_d = packed_valid;
    end
    // Invalid words leave address and count alone but still flow through WRITE.
    if (state_q == StWrite) begin
      if (valid_q) begin
        addr_d = addr_q + 32'd4;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus_io.req_ready  = (state_q == StAccept);
    bus_io.mem_we     = (state_q == StWrite) && valid_q;
    bus_io.mem_addr   = addr_q;
    bus_io.mem_wdata  = word_q;
    bus_io.busy       = (state_q != StIdle);
    bus_io.done       = (state_q == StDone);
    bus_io.err        = err_q;
    bus_io.word_count = count_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized sessions
// checked against an arithmetic RV32I encoding model.
module tb_instr_encoder;
  import instr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } tx_t;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_addr;
  logic [15:0] m_count;
  logic        m_err;

  function automatic tx_t mk(logic [2:0] fmt, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                             logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                             logic [31:0] imm, logic last);
    tx_t t;
    t.fmt = fmt; t.opc = opc; t.f3 = f3; t.f7 = f7;
    t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.last = last;
    return t;
  endfunction

  // Reference encoding built from shifts and masks with integer range checks.
  function automatic void model_encode(input tx_t t, output logic [31:0] word, output logic ok);
    int s;
    logic [31:0] regs, imm;
    s    = $signed(t.imm);
    imm  = t.imm;
    regs = (32'(t.rs2) << 20) | (32'(t.rs1) << 15) | (32'(t.f3) << 12);
    word = 32'h0;
    ok   = 1'b0;
    case (t.fmt)
      3'd0: begin
        word = (32'(t.f7) << 25) | regs | (32'(t.rd) << 7) | 32'(t.opc);
        ok   = 1'b1;
      end
      3'd1: begin
        word = ((imm & 32'hFFF) << 20) | (32'(t.rs1) << 15) | (32'(t.f3) << 12)
             | (32'(t.rd) << 7) | 32'(t.opc);
        ok   = (s >= -2048) && (s <= 2047);
      end
      3'd2: begin
        word = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'(t.opc);
        ok   = (s >= -2048) && (s <= 2047);
      end
      3'd3: begin
        word = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs
             | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(t.opc);
        ok   = (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
      end
      3'd4: begin
        word = (imm & 32'hFFFFF000) | (32'(t.rd) << 7) | 32'(t.opc);
        ok   = (imm % 4096 == 0);
      end
      3'd5: begin
        word = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
             | (32'(t.rd) << 7) | 32'(t.opc);
        ok   = (s >= -1048576) && (s <= 1048575) && (imm % 2 == 0);
      end
      default: ok = 1'b0;
    endcase
  endfunction

  // Session-level model: returns what the write cycle should show, then advances.
  task automatic model_step(input tx_t t, output logic exp_we, output logic [31:0] exp_addr,
                            output logic [31:0] exp_word);
    logic ok;
    model_encode(t, exp_word, ok);
    exp_we   = ok;
    exp_addr = m_addr;
    if (ok) begin
      m_addr = m_addr + 32'd4;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.base_addr = '0; bus.req_valid = 1'b0; bus.req_fmt = '0;
    bus.req_opcode = '0; bus.req_funct3 = '0; bus.req_funct7 = '0; bus.req_rd = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_imm = '0; bus.req_last = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the next negedge (in ACCEPT).
  task automatic do_start(input logic [31:0] base);
    bus.start = 1'b1;
    bus.base_addr = base;
    @(negedge clk);
    bus.start = 1'b0;
    m_addr = base; m_count = 16'h0; m_err = 1'b0;
  endtask

  // Waits for req_ready, transfers one request, returns at the negedge of the write cycle.
  task automatic xfer(input tx_t t, output logic we, output logic [31:0] addr,
                      output logic [31:0] wdata);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) $display("FAIL ready_timeout: req_ready=%b after %0d cycles, required 1",
                          bus.req_ready, n);
    else passed++;
    bus.req_valid = 1'b1; bus.req_fmt = t.fmt; bus.req_opcode = t.opc; bus.req_funct3 = t.f3;
    bus.req_funct7 = t.f7; bus.req_rd = t.rd; bus.req_rs1 = t.rs1; bus.req_rs2 = t.rs2;
    bus.req_imm = t.imm; bus.req_last = t.last;
    @(negedge clk);
    we = bus.mem_we; addr = bus.mem_addr; wdata = bus.mem_wdata;
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_session(output int pulses);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    logic [86:0] obs;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {bus.req_ready, bus.mem_we, bus.busy, bus.done, bus.err,
           bus.mem_addr, bus.mem_wdata, bus.word_count};
    total++;
    if (obs !== 87'h0) $display("FAIL reset_outputs: got %h, required 0", obs);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b ready=%b, required 0/0", bus.busy, bus.req_ready);
    else passed++;
  endtask

  task automatic test_r_format();
    logic we; logic [31:0] a, w; int p;
    do_start(32'h100);
    xfer(mk(FmtR, OpcOp, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1), we, a, w);
    total++;
    if (we !== 1'b1 || a !== 32'h100 || w !== 32'h002081B3)
      $display("FAIL r_format: we=%b addr=%h data=%h, required 1/00000100/002081b3", we, a, w);
    else passed++;
    finish_session(p);
    total++;
    if (p != 1 || bus.word_count !== 16'd1 || bus.busy !== 1'b0)
      $display("FAIL r_done: pulses=%0d count=%0d busy=%b, required 1/1/0",
               p, bus.word_count, bus.busy);
    else passed++;
  endtask

  task automatic test_session3();
    tx_t t[3];
    logic [31:0] exp_w[3];
    logic we; logic [31:0] a, w; int p;
    t[0] = mk(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    t[1] = mk(FmtS, OpcStore, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    t[2] = mk(FmtB, OpcBranch, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1);
    exp_w[0] = 32'hFFF00093; exp_w[1] = 32'h0020A423; exp_w[2] = 32'hFE000EE3;
    do_start(32'h200);
    for (int i = 0; i < 3; i++) begin
      xfer(t[i], we, a, w);
      total++;
      if (we !== 1'b1 || a !== 32'h200 + 32'(4 * i) || w !== exp_w[i])
        $display("FAIL session3_word%0d: we=%b addr=%h data=%h, required 1/%h/%h",
                 i, we, a, w, 32'h200 + 32'(4 * i), exp_w[i]);
      else passed++;
    end
    finish_session(p);
    total++;
    if (p != 1 || bus.word_count !== 16'd3)
      $display("FAIL session3_done: pulses=%0d count=%0d, required 1/3", p, bus.word_count);
    else passed++;
  endtask

  task automatic test_wrap();
    logic we; logic [31:0] a, w; int p;
    logic [31:0] exp_a[2];
    exp_a[0] = 32'hFFFFFFFC; exp_a[1] = 32'h0;
    do_start(32'hFFFFFFFC);
    for (int i = 0; i < 2; i++) begin
      xfer(mk(FmtU, OpcLui, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, i == 1), we, a, w);
      total++;
      if (we !== 1'b1 || a !== exp_a[i] || w !== 32'h123452B7)
        $display("FAIL wrap_word%0d: we=%b addr=%h data=%h, required 1/%h/123452b7",
                 i, we, a, w, exp_a[i]);
      else passed++;
    end
    finish_session(p);
    total++;
    if (p != 1 || bus.word_count !== 16'd2)
      $display("FAIL wrap_done: pulses=%0d count=%0d, required 1/2", p, bus.word_count);
    else passed++;
  endtask

  task automatic test_invalid();
    logic we; logic [31:0] a, w; int p;
    do_start(32'h300);
    xfer(mk(FmtR, OpcOp, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0), we, a, w);
    xfer(mk(FmtJ, OpcJal, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1), we, a, w);
    total++;
    if (we !== 1'b0)
      $display("FAIL invalid_no_write: we=%b, required 0", we);
    else passed++;
    finish_session(p);
    total++;
    if (p != 1 || bus.err !== 1'b1 || bus.word_count !== 16'd1)
      $display("FAIL invalid_status: pulses=%0d err=%b count=%0d, required 1/1/1",
               p, bus.err, bus.word_count);
    else passed++;
    do_start(32'h400);
    total++;
    if (bus.err !== 1'b0) $display("FAIL err_cleared: err=%b, required 0", bus.err);
    else passed++;
    xfer(mk(FmtR, OpcOp, 3'd0, 7'd0, 5'd2, 5'd2, 5'd2, 32'h0, 1'b1), we, a, w);
    total++;
    if (we !== 1'b1 || a !== 32'h400)
      $display("FAIL after_invalid: we=%b addr=%h, required 1/00000400", we, a);
    else passed++;
    finish_session(p);
  endtask

  task automatic test_reset_mid_write();
    logic [86:0] obs;
    logic we; logic [31:0] a, w; int p;
    do_start(32'h500);
    bus.req_valid = 1'b1; bus.req_fmt = FmtR; bus.req_opcode = OpcOp; bus.req_last = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_in_write: we=%b busy=%b, required 0/0", bus.mem_we, bus.busy);
    else passed++;
    bus.req_valid = 1'b0;
    @(negedge clk);
    obs = {bus.req_ready, bus.mem_we, bus.busy, bus.done, bus.err,
           bus.mem_addr, bus.mem_wdata, bus.word_count};
    total++;
    if (obs !== 87'h0) $display("FAIL reset_mid_outputs: got %h, required 0", obs);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    do_start(32'h600);
    xfer(mk(FmtR, OpcOp, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1), we, a, w);
    total++;
    if (we !== 1'b1 || a !== 32'h600 || w !== 32'h002081B3)
      $display("FAIL fresh_session: we=%b addr=%h data=%h, required 1/00000600/002081b3",
               we, a, w);
    else passed++;
    finish_session(p);
  endtask

  task automatic test_flow_control();
    logic we; logic [31:0] a, w; int p;
    do_start(32'h700);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b1 || bus.mem_we !== 1'b0)
        $display("FAIL stall_cycle%0d: ready=%b busy=%b we=%b, required 1/1/0",
                 i, bus.req_ready, bus.busy, bus.mem_we);
      else passed++;
      bus.start = (i == 2);
      bus.base_addr = 32'h900;
      @(negedge clk);
    end
    bus.start = 1'b0;
    xfer(mk(FmtR, OpcOp, 3'd0, 7'd0, 5'd4, 5'd4, 5'd4, 32'h0, 1'b1), we, a, w);
    total++;
    if (we !== 1'b1 || a !== 32'h700)
      $display("FAIL start_ignored: we=%b addr=%h, required 1/00000700", we, a);
    else passed++;
    finish_session(p);
  endtask

  task automatic test_random();
    tx_t t;
    logic we, exp_we; logic [31:0] a, w, exp_a, exp_w; int p, nreq;
    for (int s = 0; s < 8; s++) begin
      do_start((s % 3 == 0) ? 32'hFFFFFFF0 : {$urandom(), 2'b00} & 32'hFFFFFFFF);
      nreq = $urandom_range(1, 6);
      for (int r = 0; r < nreq; r++) begin
        t.fmt = 3'($urandom_range(0, 7));
        t.opc = 7'($urandom()); t.f3 = 3'($urandom()); t.f7 = 7'($urandom());
        t.rd = 5'($urandom()); t.rs1 = 5'($urandom()); t.rs2 = 5'($urandom());
        case ($urandom_range(0, 3))
          0:       t.imm = 32'($signed($urandom_range(0, 4095)) - 2048);
          1:       t.imm = $urandom();
          2:       t.imm = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFFFFFE;
          default: t.imm = $urandom() & 32'hFFFFF000;
        endcase
        t.last = (r == nreq - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        model_step(t, exp_we, exp_a, exp_w);
        xfer(t, we, a, w);
        total++;
        if (we !== exp_we || (exp_we && (a !== exp_a || w !== exp_w)))
          $display("FAIL random_s%0d_r%0d: we=%b addr=%h data=%h, required %b/%h/%h",
                   s, r, we, a, w, exp_we, exp_a, exp_w);
        else passed++;
      end
      finish_session(p);
      total++;
      if (p != 1 || bus.word_count !== m_count || bus.err !== m_err)
        $display("FAIL random_end_s%0d: pulses=%0d count=%0d err=%b, required 1/%0d/%b",
                 s, p, bus.word_count, bus.err, m_count, m_err);
      else passed++;
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_r_format();
    test_session3();
    test_wrap();
    test_invalid();
    test_reset_mid_write();
    test_flow_control();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
